// File: rtl/piso_pkg.sv
// piso_pkg: shared types and constants for the parallel-in serial-out transmitter.
//   state_t        : FSM encoding (IDLE, SHIFT)
//   DIR_MSB_FIRST  : load_dir value selecting MSB-first order
//   DIR_LSB_FIRST  : load_dir value selecting LSB-first order
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: loadable down-counter that counts remaining bits of a word.
//   clk      : rising-edge clock
//   rst      : asynchronous active-low clear
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one; saturates at zero
//   zero     : count is zero
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (dec && cnt != '0)  cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/piso_shift_tx.sv
// piso_shift_tx: accepts an MSB-bit word over valid/ready and shifts it out
// one bit per enabled clock, in the order chosen by load_dir at accept.
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset
//   en         : shift enable; 0 holds all state
//   load_valid : source offers a word
//   load_ready : transmitter can accept (combinational from state, counter, en)
//   load_data  : word to send
//   load_dir   : 0 = MSB first, 1 = LSB first
//   q          : serial data
//   q_valid    : q carries a word bit (same as busy)
//   busy       : a word is in flight
//   done       : one-cycle pulse after the final bit edge
module piso_shift_tx
  import piso_pkg::*;
#(
  parameter int MSB = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           load_valid,
  output logic           load_ready,
  input  logic [MSB-1:0] load_data,
  input  logic           load_dir,
  output logic           q,
  output logic           q_valid,
  output logic           busy,
  output logic           done
);

  localparam int          CW   = $clog2(MSB);
  localparam logic [CW-1:0] LAST = CW'(MSB - 1);

  state_t         state;
  logic [MSB-1:0] shreg;
  logic           dir_r;
  logic           cnt_zero;
  logic           accept;
  logic           last_edge;
  logic           cnt_dec;

  // In SHIFT a new word may only land on the edge that consumes the last bit,
  // which gives gap-free back-to-back words.
  assign load_ready = (state == IDLE) | (en & cnt_zero);
  assign accept     = load_valid & load_ready;
  assign last_edge  = (state == SHIFT) & en & cnt_zero;
  assign cnt_dec    = (state == SHIFT) & en & ~cnt_zero;

  piso_bit_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (LAST),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shreg   <= '0;
      dir_r   <= DIR_MSB_FIRST;
      q       <= 1'b0;
      q_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= last_edge;
      if (accept) begin
        // First bit goes straight onto q so it is visible the cycle after accept.
        shreg   <= load_data;
        dir_r   <= load_dir;
        q       <= (load_dir == DIR_LSB_FIRST) ? load_data[0] : load_data[MSB-1];
        state   <= SHIFT;
        busy    <= 1'b1;
        q_valid <= 1'b1;
      end else if (last_edge) begin
        state   <= IDLE;
        q       <= 1'b0;
        busy    <= 1'b0;
        q_valid <= 1'b0;
      end else if (cnt_dec) begin
        // q already holds the current output-end bit; present its neighbour.
        if (dir_r == DIR_LSB_FIRST) begin
          shreg <= shreg >> 1;
          q     <= shreg[1];
        end else begin
          shreg <= shreg << 1;
          q     <= shreg[MSB-2];
        end
      end
    end
  end

endmodule

// File: doc/piso_shift_tx.md
# piso_shift_tx

Parallel-in, serial-out shift transmitter: the sending end for the bidirectional serial-in shift register. It accepts an `MSB`-bit word through a valid/ready handshake and shifts it out one bit per enabled clock. Bit order is chosen per word so that a receiving register with the matching `dir` reconstructs the word exactly. It sits between a parallel data source and the serial link that feeds the receiver's `d` input.

## Interface
- `MSB`, default 4: word width in bits, ≥ 2.

Ports:
- `clk` in 1: single clock, rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: shift enable. When 0, the transmitter holds its state.
- `load_valid` in 1: the source offers a word.
- `load_ready` out 1: the transmitter can accept a word.
- `load_data` in `MSB`: the word to send.
- `load_dir` in 1: bit order, sampled at accept. 0 = MSB first (pairs with receiver `dir=0`, shift-in at LSB). 1 = LSB first (pairs with receiver `dir=1`, shift-in at MSB).
- `q` out 1: serial data.
- `q_valid` out 1: `q` carries a word bit.
- `busy` out 1: a word is in flight.
- `done` out 1: one-cycle pulse after the final bit of a word.

## Operation
- Reset values (asserted asynchronously while `rst=0`): `q=0`, `q_valid=0`, `busy=0`, `done=0`, `load_ready=1`. The FSM goes to IDLE and the counter clears.
- FSM states:
  - IDLE: `load_ready=1` regardless of `en`.
  - SHIFT: a word is being sent.
- Accept: a word is accepted at a rising edge with `load_valid & load_ready`. At accept:
  - `load_data` goes into the shift register, `load_dir` into the direction register, and the counter loads `MSB-1`.
  - The state becomes SHIFT.
  - The first bit (`load_data[MSB-1]` if dir=0, `load_data[0]` if dir=1) is registered onto `q`.
- SHIFT, `en=1` at an edge:
  - Counter > 0: shift the register toward the output end, present the next bit, decrement the counter.
  - Counter = 0: the last bit is consumed.
    - No accept on that edge: go to IDLE, `q=0`, `q_valid=0`.
    - Accept on that edge: back-to-back case, the next word loads with no gap.
  - `done` is set for exactly one cycle after the last-bit edge. This applies in both cases above.
- SHIFT, `en=0`: all registers hold, `q` and `q_valid` stay stable, `load_ready=0`.
- `load_ready` in SHIFT equals `en & (count==0)`, so it is combinational from `en` and state.
- `busy=1` exactly when the state is SHIFT. `q_valid` equals `busy`.
- `load_data` and `load_dir` are ignored outside the accept edge. A mid-word change has no effect.
- Reset mid-word aborts the word. No `done` is produced, and outputs return to reset values immediately.

## Timing
- All outputs are registered, except `load_ready` (combinational from state, counter and `en`).
- `q` shows bit 0 of the sequence in the cycle after accept. One word occupies exactly `MSB` enabled cycles.
- The receiver samples `q` at each rising edge where `q_valid & en`. Bit k is on `q` between enabled edges k and k+1 after accept.
- `done` rises at the edge that consumes the last bit and falls at the next edge.
- Latency from accept to `done`: `MSB` enabled cycles plus any stall cycles.
- Back-to-back: `q_valid` stays high continuously across words. The counter width is `$clog2(MSB)`, and the counter never wraps below 0.

## Structure
- Package `piso_pkg`:
  - state enum `{IDLE, SHIFT}`
  - constants `DIR_MSB_FIRST=1'b0` and `DIR_LSB_FIRST=1'b1`
- One sub-module, `piso_bit_counter`: a loadable down-counter with enable and a zero flag, `$clog2(MSB)` wide, with asynchronous active-low clear.
- The top level holds the FSM, the shift and direction registers, and the handshake.

## Test plan
All with `MSB=4`; each word is looped into the bidirectional receiver.
- Reset: hold `rst=0` for 2 cycles → `q=0`, `q_valid=0`, `busy=0`, `done=0`, `load_ready=1`. Then assert `rst=0` asynchronously mid-cycle during SHIFT → outputs clear before the next edge.
- MSB first: load `4'b1011`, dir=0, en=1 → `q` = 1,0,1,1 on cycles 1–4 after accept; `done` on cycle 5; receiver (dir=0) `out=1011`.
- LSB first: load `4'b1011`, dir=1 → `q` = 1,1,0,1; receiver (dir=1) `out=1011`.
- Back-to-back: `4'b1011` then `4'b0110` (dir=0) with `load_valid` held high → second word accepted on the 4th bit edge; `q_valid` high for 8 consecutive cycles; `q` = 1,0,1,1,0,1,1,0; two `done` pulses 4 cycles apart.
- Stall: `en=0` for 3 cycles after bit 2 of `4'b1001` → `q` holds, `load_ready=0`, sequence still 1,0,0,1; `done` delayed by 3 cycles.
- Abort: `rst=0` after bit 2 of `4'b1100`, release, then load `4'b0011` → no `done` for the aborted word; `0011` is sent completely and correctly.
